req_arbiter8: RTL and testbench

//  Shares one downstream resource among 8 requesters. Each cycle it is idle it picks
//  one requester, either fixed-priority (highest index wins) or round-robin.
//  It holds that grant until the owner releases it or a hold timeout fires.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/req_arbiter8_if.sv | 23 ++
 rtl/prio_enc8.sv | 18 +
 rtl/req_arbiter8.sv | 121 ++++++++++++
 tb/tb_req_arbiter8.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way request arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REL  = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] bit_rev8(input logic [N_REQ-1:0] v);
        logic [N_REQ-1:0] r;
        for (int i = 0; i < N_REQ; i++) begin
            r[i] = v[N_REQ-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/req_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface req_arbiter8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic             rr_mode;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req, done, rr_mode,
        input  grant, grant_id, grant_valid, timeout
    );

    modport slave (
        input  req, done, rr_mode,
        output grant, grant_id, grant_valid, timeout
    );

endinterface

// File: rtl/prio_enc8.sv
// 8-to-3 priority encoder: index of the highest set bit, plus an any-set flag.
module prio_enc8 (
    input  logic [7:0] in_vec,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = 3'd0;
        any = |in_vec;
        for (int i = 0; i < 8; i++) begin
            if (in_vec[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/req_arbiter8.sv
// Grants one shared resource to one of 8 requesters, fixed-priority or round-robin,
// holding each grant until release, owner request drop, or hold timeout.
//
//   state   | meaning
//   ST_IDLE | arbitrate; grant the winner on the next edge if any request is up
//   ST_BUSY | grant held; count hold cycles and watch for release
//   ST_REL  | one dead cycle with grant cleared; timeout flags a forced release
module req_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic           clk,
    input  logic           rst,
    req_arbiter8_if.slave  bus
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q, timeout_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [N_REQ-1:0] hi_req;
    logic [N_REQ-1:0] hi_rev;
    logic [N_REQ-1:0] req_rev;
    logic [ID_W-1:0]  fix_idx, hi_ridx, lo_ridx, win_id;
    logic             fix_any, hi_any, lo_any;
    logic             owner_rel, hold_exp;

    // Lowest-set-bit search reuses the highest-bit encoder on reversed vectors;
    // the reversed index of a 3-bit value is its bitwise complement.
    assign hi_req  = bus.req & ~((8'b1 << rr_ptr_q) - 8'b1);
    assign hi_rev  = bit_rev8(hi_req);
    assign req_rev = bit_rev8(bus.req);

    prio_enc8 u_enc_fix (.in_vec(bus.req), .idx(fix_idx), .any(fix_any));
    prio_enc8 u_enc_hi  (.in_vec(hi_rev),  .idx(hi_ridx), .any(hi_any));
    prio_enc8 u_enc_lo  (.in_vec(req_rev), .idx(lo_ridx), .any(lo_any));

    always_comb begin
        if (!bus.rr_mode) begin
            win_id = fix_idx;
        end else if (hi_any) begin
            win_id = ~hi_ridx;
        end else begin
            win_id = ~lo_ridx;
        end
    end

    assign owner_rel = bus.done || !bus.req[grant_id_q];
    assign hold_exp  = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fix_any || lo_any) begin
                    state_d       = ST_BUSY;
                    grant_d       = 8'b1 << win_id;
                    grant_id_d    = win_id;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    rr_ptr_d      = win_id + 3'd1;
                end
            end
            ST_BUSY: begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (owner_rel || hold_exp) begin
                    state_d       = ST_REL;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    timeout_d     = !owner_rel;
                end
            end
            ST_REL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Self-checking bench for req_arbiter8: directed scenarios plus random traffic,
// every cycle compared against a behavioural owner/hold model.
module tb_req_arbiter8;

    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    req_arbiter8_if bus();

    req_arbiter8 #(.MAX_HOLD(HOLD), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // model: current owner (-1 = none), completed hold cycles, next-search start
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_rel   = 1'b0;
    bit m_to    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input bit rr, input int ptr);
        if (!rr) begin
            for (int i = 7; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (r[(ptr + k) % 8]) return (ptr + k) % 8;
            end
        end
        return -1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_rel = 1'b0; m_to = 1'b0;
        end else if (m_rel) begin
            m_rel = 1'b0;
            m_to  = 1'b0;
        end else if (m_owner < 0) begin
            if (bus.req != 8'd0) begin
                m_owner = pick(bus.req, bus.rr_mode, m_ptr);
                m_held  = 0;
                m_ptr   = (m_owner + 1) % 8;
            end
        end else begin
            if (bus.done || !bus.req[m_owner]) begin
                m_owner = -1; m_rel = 1'b1; m_to = 1'b0;
            end else if (m_held + 1 == HOLD) begin
                m_owner = -1; m_rel = 1'b1; m_to = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("grant", 32'(bus.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("grant_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
        chk("timeout", 32'(bus.timeout), 32'(m_to));
        if (m_owner >= 0) chk("grant_id", 32'(bus.grant_id), 32'(m_owner));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 4 && !bus.grant_valid; i++) step();
        chk(tag, 32'(bus.grant_valid), 32'd1);
    endtask

    initial begin
        int cnt;
        bus.req = 8'd0; bus.done = 1'b0; bus.rr_mode = 1'b0;
        step();
        step();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_valid", 32'(bus.grant_valid), 32'd0);
        rst = 1'b0;

        // fixed priority, then owner drop hands over to the next highest
        bus.req = 8'b1010_0100;
        step();
        chk("fix_id7", 32'(bus.grant_id), 32'd7);
        chk("fix_grant7", 32'(bus.grant), 32'h80);
        bus.req = 8'b0010_0100;
        step();
        chk("fix_rel", 32'(bus.grant_valid), 32'd0);
        step();
        step();
        chk("fix_id5", 32'(bus.grant_id), 32'd5);

        // rr wrap: pointer is 6 after granting 5
        bus.req = 8'd0;
        step();
        step();
        bus.rr_mode = 1'b1;
        bus.req = 8'b0000_0011;
        step();
        chk("wrap_id0", 32'(bus.grant_id), 32'd0);
        bus.req = 8'd0;
        step();
        step();
        bus.req = 8'b0000_0011;
        step();
        chk("wrap_ptr1", 32'(bus.grant_id), 32'd1);

        // rr rotation with done on every grant
        do_reset();
        bus.rr_mode = 1'b1;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_valid("rr_wait");
            chk("rr_seq", 32'(bus.grant_id), 32'(k % 8));
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            chk("rr_gap", 32'(bus.grant_valid), 32'd0);
        end

        // hold timeout
        do_reset();
        bus.rr_mode = 1'b0;
        bus.req = 8'b0000_1000;
        step();
        cnt = bus.grant_valid ? 1 : 0;
        for (int i = 0; i < 40 && bus.grant_valid; i++) begin
            step();
            if (bus.grant_valid) cnt++;
        end
        chk("to_len", 32'(cnt), 32'(HOLD));
        chk("to_pulse", 32'(bus.timeout), 32'd1);
        step();
        chk("to_once", 32'(bus.timeout), 32'd0);
        step();
        chk("to_regrant", 32'(bus.grant_valid), 32'd1);
        chk("to_regrant_id", 32'(bus.grant_id), 32'd3);

        // done on the timeout cycle is a normal release; done while idle is ignored
        bus.req = 8'd0;
        step();
        step();
        bus.req = 8'b0000_1000;
        step();
        for (int i = 0; i < HOLD - 1; i++) step();
        chk("sim_pre", 32'(bus.grant_valid), 32'd1);
        bus.done = 1'b1;
        step();
        chk("sim_to0", 32'(bus.timeout), 32'd0);
        chk("sim_rel", 32'(bus.grant_valid), 32'd0);
        bus.done = 1'b0;
        bus.req = 8'd0;
        step();
        step();
        bus.done = 1'b1;
        step();
        chk("idle_done", 32'(bus.grant_valid), 32'd0);
        bus.done = 1'b0;

        // reset mid-grant clears outputs and the rr pointer
        do_reset();
        bus.rr_mode = 1'b0;
        bus.req = 8'b0010_0000;
        step();
        step();
        chk("rstm_pre", 32'(bus.grant_id), 32'd5);
        rst = 1'b1;
        step();
        chk("rstm_grant", 32'(bus.grant), 32'd0);
        chk("rstm_valid", 32'(bus.grant_valid), 32'd0);
        rst = 1'b0;
        bus.rr_mode = 1'b1;
        bus.req = 8'hFF;
        step();
        chk("rstm_rr0", 32'(bus.grant_id), 32'd0);

        // random traffic; owner usually keeps its request up
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.req = 8'($urandom);
            if ($urandom_range(0, 9) == 0) bus.req = 8'd0;
            if (m_owner >= 0 && $urandom_range(0, 31) != 0) bus.req[m_owner] = 1'b1;
            bus.done = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) bus.rr_mode = ~bus.rr_mode;
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
